// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) decode stage with registered output, 1-entry skid buffer and flush
module decode_stage #(
   parameter int PC_W     = 32,
   parameter int ENABLE_M = 0,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [4:0]        rs1,
   output logic [4:0]        rs2,
   output logic [4:0]        rd,
   output logic [3:0]        alu_ctrl,
   output logic              mdu_en,
   output logic [2:0]        mdu_op,
   output logic [2:0]        branch,
   output logic [3:0]        ls_type,
   output logic [2:0]        sext_type,
   output logic [1:0]        wb_ctrl,
   output logic              jump,
   output logic              jump_type,
   output logic              alu_src1,
   output logic              alu_src2,
   output logic              we_reg,
   output logic              we_mem,
   output logic              wb_inst_have_flag,
   output logic              illegal,
   output logic [CNT_W-1:0]  decode_cnt
);

   localparam bit M_ON = (ENABLE_M != 0);

   localparam logic [6:0] OP_BUBBLE = 7'h00;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_NOP  = 4'b1110;

   localparam logic [2:0] BR_NONE = 3'b010;
   localparam logic [2:0] SX_I    = 3'b000;
   localparam logic [2:0] SX_B    = 3'b001;
   localparam logic [2:0] SX_J    = 3'b010;
   localparam logic [2:0] SX_U    = 3'b011;
   localparam logic [2:0] SX_S    = 3'b110;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_MDU  = 2'b10;
   localparam logic [1:0] WB_PC4  = 2'b11;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [3:0] alu_ctrl;
      logic       mdu_en;
      logic [2:0] mdu_op;
      logic [2:0] branch;
      logic [3:0] ls_type;
      logic [2:0] sext_type;
      logic [1:0] wb_ctrl;
      logic       jump;
      logic       jump_type;
      logic       alu_src1;
      logic       alu_src2;
      logic       we_reg;
      logic       we_mem;
      logic       wb_flag;
      logic       illegal;
   } ctrl_t;

   function automatic ctrl_t idle_ctrl();
      ctrl_t c;
      c          = '0;
      c.alu_ctrl = ALU_NOP;
      c.branch   = BR_NONE;
      return c;
   endfunction

   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
      logic [3:0] a;
      case (f3)
         3'b000:  a = ALU_ADD;
         3'b001:  a = ALU_SLL;
         3'b010:  a = ALU_SLT;
         3'b011:  a = ALU_SLTU;
         3'b100:  a = ALU_XOR;
         3'b101:  a = ALU_SRL;
         3'b110:  a = ALU_OR;
         default: a = ALU_AND;
      endcase
      return a;
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   ctrl_t      dec;
   logic       dec_bad;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   always_comb begin
      dec     = idle_ctrl();
      dec_bad = 1'b0;
      case (opcode)
         OP_BUBBLE: begin
         end
         OP_REG: begin
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            dec.rd     = in_instr[11:7];
            dec.we_reg = 1'b1;
            if (funct7 == 7'b0000000) begin
               dec.alu_ctrl = alu_from_f3(funct3);
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec.alu_ctrl = ALU_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               dec.alu_ctrl = ALU_SRA;
            end else if (funct7 == 7'b0000001 && M_ON) begin
               dec.mdu_en  = 1'b1;
               dec.mdu_op  = funct3;
               dec.wb_ctrl = WB_MDU;
            end else begin
               dec_bad = 1'b1;
            end
         end
         OP_IMM: begin
            dec.rs1      = in_instr[19:15];
            dec.rd       = in_instr[11:7];
            dec.alu_src2 = 1'b1;
            dec.we_reg   = 1'b1;
            dec.alu_ctrl = alu_from_f3(funct3);
            // Shift-immediates carry funct7 in the upper immediate bits
            if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
               dec_bad = 1'b1;
            end
            if (funct3 == 3'b101) begin
               if (funct7 == 7'b0100000) begin
                  dec.alu_ctrl = ALU_SRA;
               end else if (funct7 != 7'b0000000) begin
                  dec_bad = 1'b1;
               end
            end
         end
         OP_LOAD: begin
            dec.rs1      = in_instr[19:15];
            dec.rd       = in_instr[11:7];
            dec.alu_ctrl = ALU_ADD;
            dec.alu_src2 = 1'b1;
            dec.we_reg   = 1'b1;
            dec.wb_ctrl  = WB_LOAD;
            dec.ls_type  = {funct3, 1'b0};
            dec.wb_flag  = 1'b1;
            dec_bad      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OP_STORE: begin
            dec.rs1       = in_instr[19:15];
            dec.rs2       = in_instr[24:20];
            dec.alu_ctrl  = ALU_ADD;
            dec.alu_src2  = 1'b1;
            dec.we_mem    = 1'b1;
            dec.ls_type   = {funct3, 1'b1};
            dec.sext_type = SX_S;
            dec.wb_flag   = 1'b1;
            dec_bad       = (funct3 > 3'b010);
         end
         OP_BRANCH: begin
            dec.rs1       = in_instr[19:15];
            dec.rs2       = in_instr[24:20];
            dec.alu_ctrl  = ALU_SUB;
            dec.branch    = funct3;
            dec.sext_type = SX_B;
            dec.wb_flag   = 1'b1;
            dec_bad       = (funct3[2:1] == 2'b01);
         end
         OP_JAL: begin
            dec.rd        = in_instr[11:7];
            dec.jump      = 1'b1;
            dec.jump_type = 1'b1;
            dec.wb_ctrl   = WB_PC4;
            dec.we_reg    = 1'b1;
            dec.sext_type = SX_J;
         end
         OP_JALR: begin
            dec.rs1       = in_instr[19:15];
            dec.rd        = in_instr[11:7];
            dec.jump      = 1'b1;
            dec.wb_ctrl   = WB_PC4;
            dec.we_reg    = 1'b1;
            dec.sext_type = SX_I;
         end
         OP_LUI: begin
            dec.rd        = in_instr[11:7];
            dec.alu_ctrl  = ALU_ADD;
            dec.alu_src2  = 1'b1;
            dec.we_reg    = 1'b1;
            dec.sext_type = SX_U;
         end
         OP_AUIPC: begin
            dec.rd        = in_instr[11:7];
            dec.alu_ctrl  = ALU_ADD;
            dec.alu_src1  = 1'b1;
            dec.alu_src2  = 1'b1;
            dec.we_reg    = 1'b1;
            dec.sext_type = SX_U;
         end
         default: begin
            dec_bad = 1'b1;
         end
      endcase
      // Illegal bundles are still delivered so EX can raise the trap
      if (dec_bad) begin
         dec         = idle_ctrl();
         dec.illegal = 1'b1;
      end
   end

   ctrl_t             out_q, out_d, skid_q, skid_d;
   logic [PC_W-1:0]   out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
   logic              out_valid_q, out_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept, out_fire, load_out;

   assign accept   = in_valid && in_ready_q && !flush;
   assign out_fire = out_valid_q && out_ready;
   assign load_out = !out_valid_q || out_ready;

   always_comb begin
      out_d        = out_q;
      out_pc_d     = out_pc_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_pc_d    = skid_pc_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (out_fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (load_out) begin
         // in_ready is low whenever skid holds data, so skid and input never compete
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_pc_d     = skid_pc_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec;
            out_pc_d    = in_pc;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_pc_d    = in_pc;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= idle_ctrl();
         out_pc_q     <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= idle_ctrl();
         skid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         out_pc_q     <= out_pc_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_pc_q    <= skid_pc_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready          = in_ready_q;
   assign out_valid         = out_valid_q;
   assign out_pc            = out_pc_q;
   assign rs1               = out_q.rs1;
   assign rs2               = out_q.rs2;
   assign rd                = out_q.rd;
   assign alu_ctrl          = out_q.alu_ctrl;
   assign mdu_en            = out_q.mdu_en;
   assign mdu_op            = out_q.mdu_op;
   assign branch            = out_q.branch;
   assign ls_type           = out_q.ls_type;
   assign sext_type         = out_q.sext_type;
   assign wb_ctrl           = out_q.wb_ctrl;
   assign jump              = out_q.jump;
   assign jump_type         = out_q.jump_type;
   assign alu_src1          = out_q.alu_src1;
   assign alu_src2          = out_q.alu_src2;
   assign we_reg            = out_q.we_reg;
   assign we_mem            = out_q.we_mem;
   assign wb_inst_have_flag = out_q.wb_flag;
   assign illegal           = out_q.illegal;
   assign decode_cnt        = cnt_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I instruction-decode stage with optional M-extension decoding and illegal-instruction detection.
- Sits between the IF/ID pipeline register and the ID/EX register.
- Takes {instr, pc} over valid/ready and emits one fully decoded control bundle per instruction.
- Provides a 1-entry skid buffer so ready is not combinationally coupled to EX backpressure, and supports flush on branch/jump redirect.

Parameters:
- PC_W, 32, width of the PC carried with each instruction.
- ENABLE_M, 0, 1 = decode MUL/DIV/REM (funct7=0000001 on R-type); 0 = those encodings are illegal.
- CNT_W, 32, width of the retired-decode counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all held/in-flight decode state.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  PC_W  PC of decoded instruction.
- rs1, rs2, rd  out  5 each  register indices; 0 when the format does not use the field.
- alu_ctrl  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SLT 0110, SLTU 0111, SRL 1000, SRA 1001, NOP 1110.
- mdu_en  out  1  instruction is M-extension.
- mdu_op  out  3  funct3 of M-op; 0 when mdu_en=0.
- branch  out  3  BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111, not-branch 010.
- ls_type  out  4  LB 0000, LH 0010, LW 0100, LBU 1000, LHU 1010, SB 0001, SH 0011, SW 0101; 0 otherwise.
- sext_type  out  3  I 000, B 001, J 010, U 011, S 110.
- wb_ctrl  out  2  00 ALU, 01 load, 10 MDU, 11 PC+4.
- jump, jump_type  out  1 each  jump present; 1 = JAL, 0 = JALR.
- alu_src1, alu_src2  out  1 each  1 = PC (AUIPC) / 1 = immediate (I, S, L, AUIPC, LUI).
- we_reg, we_mem  out  1 each  register / memory write enable.
- wb_inst_have_flag  out  1  set for branch, load, store.
- illegal  out  1  undecodable instruction.
- decode_cnt  out  CNT_W  count of bundles handed downstream.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, skid empty, in_ready=0 while rst is high, decode_cnt=0. All fields 0 except alu_ctrl=NOP and branch=010.
- in_ready = !skid_valid && !rst (registered).
- Transfer rules: input transfers on in_valid&&in_ready; output transfers on out_valid&&out_ready.
- Latency: the accepted instruction's bundle appears on outputs the next cycle.
- Output register loads when empty or transferring out:
  - from skid if skid_valid;
  - else from the input-side decode.
- If input is accepted while the output register is valid and not draining, the decoded bundle goes to skid; in_ready drops the next cycle.
- Skid drains into the output register on the first out transfer. Order is strictly preserved.
- Output fields stay stable while out_valid && !out_ready.
- Decode is pure combinational on in_instr and is registered; no field ever holds a stale value (unused fields forced to 0).
- Opcode 0x00: bubble. we_reg=we_mem=0, alu_ctrl=NOP, illegal=0.
- Illegal when any of the following hold:
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001 when ENABLE_M};
  - 0100000 with funct3 other than 000/101;
  - SRLI/SRAI or SLLI with bad funct7;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >010.
- When illegal=1: we_reg=we_mem=jump=mdu_en=0, alu_ctrl=NOP, branch=010, all else 0. Still delivered as a valid bundle so EX can trap.
- LUI: rs1=0, alu ADD, alu_src2=1. JAL/JALR: alu NOP, wb_ctrl=11.
- Flush: at the next edge out_valid=0 and skid cleared. An input presented in the flush cycle is dropped (not accepted). Flush has no effect on decode_cnt.
- Flush and out transfer in the same cycle: the transfer counts.
- decode_cnt increments by 1 per out transfer and wraps modulo 2^CNT_W.
- rst has priority over flush.

Test Plan:
- Reset then 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_ctrl=0000, we_reg=1, wb_ctrl=00, decode_cnt→1 after transfer.
- 0x027302B3 (mul x5,x6,x7): ENABLE_M=1 → mdu_en=1, mdu_op=000, wb_ctrl=10, rd=5. ENABLE_M=0 → illegal=1, we_reg=0.
- 0x00812203 (lw x4,8(x2)) → ls_type=0100, wb_ctrl=01, sext_type=000, alu_src2=1, wb_inst_have_flag=1. Then 0xFFFFFFFF → illegal=1, alu_ctrl=1110.
- Backpressure: out_ready=0 for 3 cycles while issuing A then B → A held stable, B in skid, in_ready=0. Release → A then B on consecutive cycles, decode_cnt +2.
- Flush with A on output and B in skid → next cycle out_valid=0, in_ready=1. Neither is ever delivered. A new instruction in the flush cycle is not accepted.
- CNT_W=4: 17 transfers → decode_cnt=1. Also assert rst mid-stall → all outputs return to reset values the next cycle.
